// File: rtl/time_adjust_counter_pkg.sv
// Shared widths, direction encodings and helpers for the time-of-day register bank.
// bin2bcd8 is only called when BCD_OUT_EN is defined.
package time_pkg;

    localparam int unsigned SEC_W = 6;
    localparam int unsigned MIN_W = 6;
    localparam int unsigned HR_W  = 5;

    localparam logic DIR_INC = 1'b1;
    localparam logic DIR_DEC = 1'b0;

    // Per-field step request presented to a mod_counter
    typedef struct packed {
        logic inc;
        logic dec;
    } step_t;

    // Binary 0..99 to packed {tens, units}
    function automatic logic [7:0] bin2bcd8(input logic [6:0] bin);
        logic [3:0] tens;
        logic [3:0] units;
        tens  = 4'(bin / 7'd10);
        units = 4'(bin % 7'd10);
        return {tens, units};
    endfunction

endpackage

// File: rtl/time_adjust_counter_if.sv
// Adjust/tick inputs and time outputs of time_adjust_counter.
// The BCD outputs exist only when BCD_OUT_EN is defined.
interface time_adjust_counter_if;

    logic                       tick_1hz;
    logic                       c1s;
    logic                       c1m;
    logic                       c1h;
    logic                       c0s;
    logic                       c0m;
    logic                       c0h;
    logic                       dis_s;
    logic                       dis_m;
    logic                       dis_h;
    logic [time_pkg::SEC_W-1:0] sec;
    logic [time_pkg::MIN_W-1:0] min;
    logic [time_pkg::HR_W-1:0]  hour;
    logic                       day_wrap;
`ifdef BCD_OUT_EN
    logic [7:0]                 sec_bcd;
    logic [7:0]                 min_bcd;
    logic [7:0]                 hour_bcd;

    modport master (
        output tick_1hz, c1s, c1m, c1h, c0s, c0m, c0h, dis_s, dis_m, dis_h,
        input  sec, min, hour, day_wrap, sec_bcd, min_bcd, hour_bcd
    );

    modport slave (
        input  tick_1hz, c1s, c1m, c1h, c0s, c0m, c0h, dis_s, dis_m, dis_h,
        output sec, min, hour, day_wrap, sec_bcd, min_bcd, hour_bcd
    );
`else
    modport master (
        output tick_1hz, c1s, c1m, c1h, c0s, c0m, c0h, dis_s, dis_m, dis_h,
        input  sec, min, hour, day_wrap
    );

    modport slave (
        input  tick_1hz, c1s, c1m, c1h, c0s, c0m, c0h, dis_s, dis_m, dis_h,
        output sec, min, hour, day_wrap
    );
`endif

endinterface

// File: rtl/time_adjust_counter_mod_counter.sv
// Modulo-N up/down counter for one time field; inc wins over dec.
// wrap flags, combinationally, that this cycle's inc takes the field from N-1 to 0.
module mod_counter #(
    parameter int unsigned N = 60,
    parameter int unsigned W = 6
) (
    input  logic         clk50,
    input  logic         reset,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] q,
    output logic         wrap
);

    localparam logic [W-1:0] MAX_V  = W'(N - 1);
    localparam logic [W-1:0] ZERO_V = {W{1'b0}};
    localparam logic [W-1:0] ONE_V  = W'(1);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    // Next value and inc-wrap detection
    always_comb begin
        q_d  = q_q;
        wrap = 1'b0;
        if (inc) begin
            if (q_q == MAX_V) begin
                q_d  = ZERO_V;
                wrap = 1'b1;
            end else begin
                q_d  = q_q + ONE_V;
            end
        end else if (dec) begin
            if (q_q == ZERO_V) begin
                q_d = MAX_V;
            end else begin
                q_d = q_q - ONE_V;
            end
        end else begin
            q_d = q_q;
        end
    end

    // Field register
    always_ff @(posedge clk50 or negedge reset) begin
        if (!reset) begin
            q_q <= ZERO_V;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/time_adjust_counter.sv
// HH:MM:SS register bank driven by a 1 Hz tick and the key FSM's push/direction adjust protocol.
// Optional macro BCD_OUT_EN adds registered BCD copies of the three fields.
module time_adjust_counter
    import time_pkg::*;
#(
    parameter int unsigned SECONDS = 60,
    parameter int unsigned MINUTES = 60,
    parameter int unsigned HOURS   = 24
) (
    input  logic                 clk50,
    input  logic                 reset,
    time_adjust_counter_if.slave bus
);

    logic             c1s_q;
    logic             c1m_q;
    logic             c1h_q;
    logic             armed_q;
    logic             tick_pend_q;
    logic             tick_pend_d;
    logic             day_wrap_q;
    logic             day_wrap_d;

    logic             ev_s_s;
    logic             ev_m_s;
    logic             ev_h_s;
    logic             any_ev_s;
    logic             any_dis_s;
    logic             tick_apply_s;

    step_t            sec_step_s;
    step_t            min_step_s;
    step_t            hour_step_s;
    logic             sec_wrap_s;
    logic             min_wrap_s;
    logic             hour_wrap_s;
    logic [SEC_W-1:0] sec_s;
    logic [MIN_W-1:0] min_s;
    logic [HR_W-1:0]  hour_s;

    // Push-strobe history; armed_q blinds the first cycle after reset so a held-low strobe is not an event
    always_ff @(posedge clk50 or negedge reset) begin
        if (!reset) begin
            c1s_q   <= 1'b1;
            c1m_q   <= 1'b1;
            c1h_q   <= 1'b1;
            armed_q <= 1'b0;
        end else begin
            c1s_q   <= bus.c1s;
            c1m_q   <= bus.c1m;
            c1h_q   <= bus.c1h;
            armed_q <= 1'b1;
        end
    end

    // Adjust events, tick arbitration and the single-entry pending tick
    always_comb begin
        ev_s_s       = armed_q & c1s_q & ~bus.c1s;
        ev_m_s       = armed_q & c1m_q & ~bus.c1m;
        ev_h_s       = armed_q & c1h_q & ~bus.c1h;
        any_ev_s     = ev_s_s | ev_m_s | ev_h_s;
        any_dis_s    = bus.dis_s | bus.dis_m | bus.dis_h;
        tick_apply_s = (bus.tick_1hz | tick_pend_q) & ~any_ev_s & ~any_dis_s;
        if (any_dis_s) begin
            tick_pend_d = 1'b0;
        end else if (any_ev_s) begin
            tick_pend_d = tick_pend_q | bus.tick_1hz;
        end else begin
            tick_pend_d = 1'b0;
        end
    end

    // Seconds: the tick or its own adjust
    always_comb begin
        sec_step_s.inc = tick_apply_s | (ev_s_s & (bus.c0s == DIR_INC));
        sec_step_s.dec = ev_s_s & (bus.c0s == DIR_DEC);
    end

    // Minutes: seconds carry or its own adjust (adjust never carries)
    always_comb begin
        min_step_s.inc = (tick_apply_s & sec_wrap_s) | (ev_m_s & (bus.c0m == DIR_INC));
        min_step_s.dec = ev_m_s & (bus.c0m == DIR_DEC);
    end

    // Hours: minutes carry or its own adjust
    always_comb begin
        hour_step_s.inc = (tick_apply_s & sec_wrap_s & min_wrap_s) | (ev_h_s & (bus.c0h == DIR_INC));
        hour_step_s.dec = ev_h_s & (bus.c0h == DIR_DEC);
    end

    // Day rollover only counts when the tick itself carried through all three fields
    always_comb begin
        day_wrap_d = tick_apply_s & sec_wrap_s & min_wrap_s & hour_wrap_s;
    end

    // Pending tick and day-wrap pulse registers
    always_ff @(posedge clk50 or negedge reset) begin
        if (!reset) begin
            tick_pend_q <= 1'b0;
            day_wrap_q  <= 1'b0;
        end else begin
            tick_pend_q <= tick_pend_d;
            day_wrap_q  <= day_wrap_d;
        end
    end

    mod_counter #(.N(SECONDS), .W(SEC_W)) u_sec (
        .clk50 (clk50),
        .reset (reset),
        .inc   (sec_step_s.inc),
        .dec   (sec_step_s.dec),
        .q     (sec_s),
        .wrap  (sec_wrap_s)
    );

    mod_counter #(.N(MINUTES), .W(MIN_W)) u_min (
        .clk50 (clk50),
        .reset (reset),
        .inc   (min_step_s.inc),
        .dec   (min_step_s.dec),
        .q     (min_s),
        .wrap  (min_wrap_s)
    );

    mod_counter #(.N(HOURS), .W(HR_W)) u_hour (
        .clk50 (clk50),
        .reset (reset),
        .inc   (hour_step_s.inc),
        .dec   (hour_step_s.dec),
        .q     (hour_s),
        .wrap  (hour_wrap_s)
    );

    assign bus.sec      = sec_s;
    assign bus.min      = min_s;
    assign bus.hour     = hour_s;
    assign bus.day_wrap = day_wrap_q;

`ifdef BCD_OUT_EN
    logic [7:0] sec_bcd_q;
    logic [7:0] min_bcd_q;
    logic [7:0] hour_bcd_q;

    // BCD copies trail the binary fields by one cycle
    always_ff @(posedge clk50 or negedge reset) begin
        if (!reset) begin
            sec_bcd_q  <= 8'h00;
            min_bcd_q  <= 8'h00;
            hour_bcd_q <= 8'h00;
        end else begin
            sec_bcd_q  <= bin2bcd8(7'(sec_s));
            min_bcd_q  <= bin2bcd8(7'(min_s));
            hour_bcd_q <= bin2bcd8(7'(hour_s));
        end
    end

    assign bus.sec_bcd  = sec_bcd_q;
    assign bus.min_bcd  = min_bcd_q;
    assign bus.hour_bcd = hour_bcd_q;
`endif

endmodule

// File: tb/tb_time_adjust_counter.sv
// Scoreboard bench for time_adjust_counter: a seconds-of-day reference model predicts every cycle,
// a monitor compares the DUT one step after each clock edge.
module tb_time_adjust_counter;

    logic clk50 = 1'b0;
    logic reset;

    time_adjust_counter_if bus();

    time_adjust_counter #(.SECONDS(60), .MINUTES(60), .HOURS(24)) dut (
        .clk50 (clk50),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #10 clk50 = ~clk50;

    typedef struct {
        int s;
        int m;
        int h;
        bit dw;
        bit rst;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    exp_t prev_e;
    int   checks = 0;
    int   errors = 0;

    // Reference model: time kept as seconds since midnight
    int t_m;
    bit pend_m;
    bit first_m;
    bit c1s_m;
    bit c1m_m;
    bit c1h_m;

    function automatic int adj(input int v, input int modn, input logic up);
        return up ? (v + 1) % modn : (v + modn - 1) % modn;
    endfunction

    function automatic int to_bcd(input int v);
        return (v / 10) * 16 + (v % 10);
    endfunction

    task automatic model_step();
        exp_t e;
        int   s, m, h;
        bit   es, em, eh, anyev, anydis;
        e.dw  = 1'b0;
        e.rst = 1'b0;
        if (reset == 1'b0) begin
            t_m = 0; pend_m = 1'b0; first_m = 1'b1;
            c1s_m = 1'b1; c1m_m = 1'b1; c1h_m = 1'b1;
            e.s = 0; e.m = 0; e.h = 0; e.rst = 1'b1;
            exp_q.push_back(e);
            return;
        end
        es = !first_m && c1s_m && (bus.c1s == 1'b0);
        em = !first_m && c1m_m && (bus.c1m == 1'b0);
        eh = !first_m && c1h_m && (bus.c1h == 1'b0);
        first_m = 1'b0;
        anyev  = es || em || eh;
        anydis = bus.dis_s || bus.dis_m || bus.dis_h;
        s = t_m % 60; m = (t_m / 60) % 60; h = t_m / 3600;
        if (es) s = adj(s, 60, bus.c0s);
        if (em) m = adj(m, 60, bus.c0m);
        if (eh) h = adj(h, 24, bus.c0h);
        t_m = h * 3600 + m * 60 + s;
        if (anydis) begin
            pend_m = 1'b0;
        end else if (anyev) begin
            if (bus.tick_1hz) pend_m = 1'b1;
        end else if (bus.tick_1hz || pend_m) begin
            t_m = t_m + 1;
            if (t_m == 86400) begin
                t_m  = 0;
                e.dw = 1'b1;
            end
            pend_m = 1'b0;
        end
        c1s_m = bus.c1s; c1m_m = bus.c1m; c1h_m = bus.c1h;
        e.s = t_m % 60; e.m = (t_m / 60) % 60; e.h = t_m / 3600;
        exp_q.push_back(e);
    endtask

    // One clock: predict the effect of the current inputs, then move to the next falling edge
    task automatic cyc();
        model_step();
        @(negedge clk50);
    endtask

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic press(input bit ps, input bit pm, input bit ph, input bit us, input bit um, input bit uh);
        bus.c0s = us; bus.c0m = um; bus.c0h = uh;
        bus.c1s = ~ps; bus.c1m = ~pm; bus.c1h = ~ph;
        cyc();
        bus.c1s = 1'b1; bus.c1m = 1'b1; bus.c1h = 1'b1;
        cyc();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cyc();
        cyc();
        reset = 1'b1;
        cyc();
    endtask

    // Monitor: one expectation per clock edge, compared just after the edge
    always @(posedge clk50) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            if (int'(bus.sec) != mon_e.s || int'(bus.min) != mon_e.m ||
                int'(bus.hour) != mon_e.h || bus.day_wrap !== mon_e.dw) begin
                errors++;
                $display("FAIL scoreboard @%0t: got %0d:%0d:%0d wrap=%0b, expected %0d:%0d:%0d wrap=%0b",
                         $time, bus.hour, bus.min, bus.sec, bus.day_wrap,
                         mon_e.h, mon_e.m, mon_e.s, mon_e.dw);
            end
`ifdef BCD_OUT_EN
            checks++;
            if (int'(bus.sec_bcd)  != (mon_e.rst ? 0 : to_bcd(prev_e.s)) ||
                int'(bus.min_bcd)  != (mon_e.rst ? 0 : to_bcd(prev_e.m)) ||
                int'(bus.hour_bcd) != (mon_e.rst ? 0 : to_bcd(prev_e.h))) begin
                errors++;
                $display("FAIL bcd @%0t: got %h:%h:%h, expected from %0d:%0d:%0d",
                         $time, bus.hour_bcd, bus.min_bcd, bus.sec_bcd, prev_e.h, prev_e.m, prev_e.s);
            end
`endif
            prev_e = mon_e;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        prev_e = '{0, 0, 0, 1'b0, 1'b1};
        reset = 1'b0;
        bus.tick_1hz = 1'b0;
        bus.c1s = 1'b1; bus.c1m = 1'b1; bus.c1h = 1'b1;
        bus.c0s = 1'b1; bus.c0m = 1'b1; bus.c0h = 1'b1;
        bus.dis_s = 1'b0; bus.dis_m = 1'b0; bus.dis_h = 1'b0;
        @(negedge clk50);
        check("reset_sec", int'(bus.sec), 0);
        check("reset_wrap", int'(bus.day_wrap), 0);
        do_reset();

        // 61 ticks from zero
        repeat (61) begin
            bus.tick_1hz = 1'b1; cyc();
            bus.tick_1hz = 1'b0; cyc();
        end
        check("t1_sec", int'(bus.sec), 1);
        check("t1_min", int'(bus.min), 1);
        check("t1_hour", int'(bus.hour), 0);

        // Simultaneous decrements from midnight, then roll the day over
        do_reset();
        press(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("k3_hour", int'(bus.hour), 23);
        check("k3_min", int'(bus.min), 59);
        check("k3_sec", int'(bus.sec), 59);
        bus.tick_1hz = 1'b1; cyc();
        bus.tick_1hz = 1'b0;
        check("wrap_pulse", int'(bus.day_wrap), 1);
        check("wrap_hour", int'(bus.hour), 0);
        cyc();
        check("wrap_clear", int'(bus.day_wrap), 0);

        // Seconds adjust wraps without borrowing or carrying
        press(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("dec_sec", int'(bus.sec), 59);
        check("dec_min", int'(bus.min), 0);
        press(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        check("inc_sec", int'(bus.sec), 0);
        check("inc_min", int'(bus.min), 0);

        // Tick colliding with a minutes event is deferred by one cycle
        bus.tick_1hz = 1'b1; bus.c0m = 1'b1; bus.c1m = 1'b0; cyc();
        bus.tick_1hz = 1'b0; bus.c1m = 1'b1;
        check("coll_min", int'(bus.min), 1);
        check("coll_sec0", int'(bus.sec), 0);
        cyc();
        check("coll_sec1", int'(bus.sec), 1);
        cyc();
        check("coll_sec_once", int'(bus.sec), 1);

        // Set mode freezes ticks; reset with a strobe held low yields no event
        bus.dis_m = 1'b1;
        repeat (5) begin
            bus.tick_1hz = 1'b1; cyc();
            bus.tick_1hz = 1'b0; cyc();
        end
        check("frz_sec", int'(bus.sec), 1);
        check("frz_min", int'(bus.min), 1);
        bus.c1h = 1'b0;
        reset = 1'b0; cyc(); cyc();
        reset = 1'b1; cyc(); cyc();
        check("rst_hold_hour", int'(bus.hour), 0);
        bus.c1h = 1'b1; cyc();
        bus.c0h = 1'b1; bus.c1h = 1'b0; cyc();
        check("rst_next_fall", int'(bus.hour), 1);
        bus.c1h = 1'b1; bus.dis_m = 1'b0; cyc();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bus.tick_1hz = ($urandom_range(0, 3) == 0);
            bus.c1s = ($urandom_range(0, 4) != 0);
            bus.c1m = ($urandom_range(0, 5) != 0);
            bus.c1h = ($urandom_range(0, 6) != 0);
            bus.c0s = 1'($urandom_range(0, 1));
            bus.c0m = 1'($urandom_range(0, 1));
            bus.c0h = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 40) == 0) bus.dis_s = ~bus.dis_s;
            if ($urandom_range(0, 60) == 0) bus.dis_m = ~bus.dis_m;
            if ($urandom_range(0, 80) == 0) bus.dis_h = ~bus.dis_h;
            reset = ($urandom_range(0, 600) == 0) ? 1'b0 : 1'b1;
            cyc();
        end
        reset = 1'b1; bus.tick_1hz = 1'b0;
        bus.c1s = 1'b1; bus.c1m = 1'b1; bus.c1h = 1'b1;
        cyc();
        @(posedge clk50);
        #2;
        check("sb_drain", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
